multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle FSM control unit for the MIPS datapath; next generation of the single-cycle decoder.
//  Sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction and waits on a mem_ready handshake.
//  Drives datapath mux selects, memory strobes, ALU op and register/PC/IR write enables.
//  Bounds memory waits with a timeout and traps on illegal opcodes.
// PARAMETERS
//  MEM_TIMEOUT  16  consecutive mem_ready-low cycles in a memory state before TRAP (>=2)
//  CNT_W        5   wait-counter width; must hold MEM_TIMEOUT-1
//  ALU_W        3   aluctrl width; codes zero-extended to ALU_W
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      asynchronous, active-high reset
//  op        in   6      instruction opcode (IR[31:26])
//  func      in   6      R-type function (IR[5:0])
//  zero      in   1      ALU zero flag
//  mem_ready in   1      memory completes current read/write this cycle
//  muxctrl   out  8      [0]iord [1]regdst [2]memtoreg [3]alusrca [5:4]alusrcb(00 B,01 4,10 imm,11 imm<<2) [7:6]pcsrc(00 alu,01 aluout,10 jump)
//  memctrl   out  2      [0]mem_rd [1]mem_wr
//  aluctrl   out  ALU_W  000 add, 001 sub, 010 and, 011 or, 100 slt
//  ir_we     out  1      instruction register write
//  pc_we     out  1      PC write
//  reg_we    out  1      register file write
//  err       out  1      sticky trap flag
//  state     out  4      current state code (debug)
// BEHAVIOUR
//  - States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 REX=6 ALUWB=7 BRANCH=8 ADDIEX=9 JUMP=10 TRAP=11.
//  - Reset (async): state=FETCH, wait counter=0, err=0; all outputs 0 while reset is high.
//  - Outputs are decoded from state (Moore). Exceptions: FETCH ir_we/pc_we = mem_ready; BRANCH pc_we = zero.
//  - FETCH: mem_rd, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00. Stay until mem_ready=1, then DECODE.
//  - DECODE: alusrcb=11, add (branch target). Dispatch on op:
//      000000 -> REX; 100011 lw / 101011 sw -> MEMADR; 000100 beq -> BRANCH; 001000 addi -> ADDIEX;
//      000010 j -> JUMP; any other op -> TRAP.
//  - REX: alusrca=1, alusrcb=00. func 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
//    -> ALUWB with regdst=1. Any other func -> TRAP.
//  - ADDIEX: alusrca=1, alusrcb=10, add -> ALUWB with regdst=0.
//  - ALUWB: reg_we=1, memtoreg=0; regdst as selected -> FETCH. Regdst is held in a flop set on REX/ADDIEX entry.
//  - MEMADR: alusrca=1, alusrcb=10, add; lw -> MEMRD, sw -> MEMWR.
//  - MEMRD: mem_rd, iord=1; on mem_ready -> MEMWB. MEMWB: reg_we, memtoreg=1, regdst=0 -> FETCH.
//  - MEMWR: mem_wr, iord=1; on mem_ready -> FETCH.
//  - BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01 -> FETCH.
//  - JUMP: pcsrc=10, pc_we=1 -> FETCH. Every non-memory state takes exactly 1 cycle.
//  - Latency in cycles with zero-wait memory: R/addi 4, lw 5, sw 4, beq 3, j 3. Each memory wait cycle adds 1.
//  - Wait counter:
//      clears on entry to FETCH/MEMRD/MEMWR and whenever mem_ready=1;
//      increments each cycle in those states while mem_ready=0;
//      at count MEM_TIMEOUT-1 with mem_ready still 0 -> TRAP (no strobes issued that cycle).
//  - If mem_ready=1 arrives on the final timeout cycle, completion wins; no TRAP.
//  - TRAP: all outputs 0, err=1. Absorbing state; only reset exits it.
//  - mem_ready is ignored outside FETCH/MEMRD/MEMWR.
//  - Reset mid-instruction aborts it; no partial write enables are emitted after the reset edge.
// CONFIGURATION
//  - CTRL_BNE_EN defined: op 000101 (bne) -> BRANCH with a bne flag; in BRANCH, pc_we = ~zero.
//  - CTRL_BNE_EN undefined: op 000101 -> TRAP.
// TESTING
//  1. reset=1 mid-MEMRD, then release -> outputs 0 during reset; next cycle state=0, memctrl=01.
//  2. add (op 0, func 100000), mem_ready tied 1 -> states 0,1,6,7; ALUWB: reg_we=1, muxctrl[1]=1, aluctrl=000.
//  3. lw, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB: reg_we=1, muxctrl[2]=1.
//  4. beq, zero=1 -> BRANCH: pc_we=1, pcsrc=01. Repeat with zero=0 -> pc_we=0.
//  5. op=111111 -> TRAP after DECODE, err=1; stays in TRAP until reset.
//  6. mem_ready=0 in FETCH, MEM_TIMEOUT=16 -> TRAP after 16 cycles.
//     Same, mem_ready=1 on cycle 16 -> DECODE, err=0.
//  7. bne (000101), zero=0 -> pc_we=1 with CTRL_BNE_EN; TRAP without it.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXECUTE/MEM/WB with a mem_ready handshake, memory-wait timeout and illegal-op trap.
// Optional bne support is enabled by defining CTRL_BNE_EN.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5,
  parameter int ALU_W       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [7:0]       muxctrl,
  output logic [1:0]       memctrl,
  output logic [ALU_W-1:0] aluctrl,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic             err,
  output logic [3:0]       state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    REX = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9, JUMP = 4'd10, TRAP = 4'd11
  } state_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                         OP_BNE = 6'b000101;
  localparam logic [ALU_W-1:0] A_ADD = ALU_W'(0), A_SUB = ALU_W'(1), A_AND = ALU_W'(2),
                               A_OR = ALU_W'(3), A_SLT = ALU_W'(4);

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt;
  logic             regdst_q, bne_q, err_q;
  logic             mem_st, timeout, func_ok;
  logic [ALU_W-1:0] r_alu;

  assign mem_st  = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
  assign timeout = mem_st && !mem_ready && (cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    func_ok = 1'b1;
    r_alu   = A_ADD;
    case (func)
      6'b100000: r_alu = A_ADD;
      6'b100010: r_alu = A_SUB;
      6'b100100: r_alu = A_AND;
      6'b100101: r_alu = A_OR;
      6'b101010: r_alu = A_SLT;
      default:   func_ok = 1'b0;
    endcase
  end

  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:  nxt = timeout ? TRAP : (mem_ready ? DECODE : FETCH);
      DECODE: begin
        case (op)
          OP_R:          nxt = REX;
          OP_LW, OP_SW:  nxt = MEMADR;
          OP_BEQ:        nxt = BRANCH;
          OP_ADDI:       nxt = ADDIEX;
          OP_J:          nxt = JUMP;
`ifdef CTRL_BNE_EN
          OP_BNE:        nxt = BRANCH;
`endif
          default:       nxt = TRAP;
        endcase
      end
      MEMADR: nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  nxt = timeout ? TRAP : (mem_ready ? MEMWB : MEMRD);
      MEMWR:  nxt = timeout ? TRAP : (mem_ready ? FETCH : MEMWR);
      REX:    nxt = func_ok ? ALUWB : TRAP;
      ADDIEX: nxt = ALUWB;
      MEMWB, ALUWB, BRANCH, JUMP: nxt = FETCH;
      default: nxt = TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur      <= FETCH;
      cnt      <= '0;
      regdst_q <= 1'b0;
      bne_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cur <= nxt;
      // Counter only runs while a memory state is stalled; any completion or exit clears it.
      cnt <= (mem_st && !mem_ready && !timeout) ? cnt + 1'b1 : '0;
      if (cur == DECODE) begin
        regdst_q <= (op == OP_R);
        bne_q    <= (op == OP_BNE);
      end
      if (nxt == TRAP) err_q <= 1'b1;
    end
  end

  always_comb begin
    muxctrl = '0;
    memctrl = '0;
    aluctrl = A_ADD;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    reg_we  = 1'b0;
    case (cur)
      FETCH:  begin memctrl = 2'b01; muxctrl[5:4] = 2'b01; ir_we = mem_ready; pc_we = mem_ready; end
      DECODE: muxctrl[5:4] = 2'b11;
      MEMADR: begin muxctrl[3] = 1'b1; muxctrl[5:4] = 2'b10; end
      MEMRD:  begin memctrl = 2'b01; muxctrl[0] = 1'b1; end
      MEMWB:  begin reg_we = 1'b1; muxctrl[2] = 1'b1; end
      MEMWR:  begin memctrl = 2'b10; muxctrl[0] = 1'b1; end
      REX:    begin muxctrl[3] = 1'b1; aluctrl = r_alu; end
      ALUWB:  begin reg_we = 1'b1; muxctrl[1] = regdst_q; end
      BRANCH: begin
        muxctrl[3] = 1'b1; muxctrl[7:6] = 2'b01; aluctrl = A_SUB;
        pc_we = bne_q ? ~zero : zero;
      end
      ADDIEX: begin muxctrl[3] = 1'b1; muxctrl[5:4] = 2'b10; end
      JUMP:   begin muxctrl[7:6] = 2'b10; pc_we = 1'b1; end
      default: ;
    endcase
    // Timeout cycle and reset both silence every strobe and enable.
    if (reset || timeout) begin
      muxctrl = '0;
      memctrl = '0;
      aluctrl = A_ADD;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      reg_we  = 1'b0;
    end
  end

  assign err   = err_q;
  assign state = cur;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller; expected values hand-derived from the control table.
module tb_multicycle_controller;
  logic       clk = 1'b0, reset = 1'b1;
  logic [5:0] op = '0, func = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic [7:0] muxctrl;
  logic [1:0] memctrl;
  logic [2:0] aluctrl;
  logic       ir_we, pc_we, reg_we, err;
  logic [3:0] state;
  int         n_vec = 0, n_err = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .muxctrl(muxctrl), .memctrl(memctrl), .aluctrl(aluctrl), .ir_we(ir_we), .pc_we(pc_we),
    .reg_we(reg_we), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // state, muxctrl, memctrl, aluctrl, {ir_we,pc_we,reg_we,err} checked as one vector
  task automatic vec(input string tag, input logic [3:0] s, input logic [7:0] m, input logic [1:0] mc,
                     input logic [2:0] a, input logic [3:0] we);
    #2;
    chk(tag, {state, muxctrl, memctrl, aluctrl, ir_we, pc_we, reg_we, err}, {s, m, mc, a, we});
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Zero-wait fetch+decode of one instruction
  task automatic fd(input string tag, input logic [5:0] o);
    op = o; mem_ready = 1'b1;
    vec({tag, "_fetch"}, 4'd0, 8'h10, 2'b01, 3'd0, 4'b1100); tick();
    vec({tag, "_decode"}, 4'd1, 8'h30, 2'b00, 3'd0, 4'b0000); tick();
  endtask

  initial begin
    tick();
    vec("reset_hold", 4'd0, 8'h00, 2'b00, 3'd0, 4'b0000);
    do_reset();

    // add: FETCH DECODE REX ALUWB
    func = 6'b100000;
    fd("add", 6'b000000);
    vec("add_rex", 4'd6, 8'h08, 2'b00, 3'd0, 4'b0000); tick();
    vec("add_aluwb", 4'd7, 8'h02, 2'b00, 3'd0, 4'b0010); tick();

    // slt / sub ALU codes in REX
    func = 6'b101010;
    fd("slt", 6'b000000);
    vec("slt_rex", 4'd6, 8'h08, 2'b00, 3'd4, 4'b0000); tick(); tick();
    func = 6'b100010;
    fd("sub", 6'b000000);
    vec("sub_rex", 4'd6, 8'h08, 2'b00, 3'd1, 4'b0000); tick(); tick();

    // lw with 3 wait cycles in MEMRD
    fd("lw", 6'b100011);
    vec("lw_memadr", 4'd2, 8'h28, 2'b00, 3'd0, 4'b0000); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vec("lw_memrd_wait", 4'd3, 8'h01, 2'b01, 3'd0, 4'b0000); tick();
    end
    mem_ready = 1'b1;
    vec("lw_memrd_done", 4'd3, 8'h01, 2'b01, 3'd0, 4'b0000); tick();
    vec("lw_memwb", 4'd4, 8'h04, 2'b00, 3'd0, 4'b0010); tick();
    vec("lw_back_fetch", 4'd0, 8'h10, 2'b01, 3'd0, 4'b1100);

    // sw zero-wait
    fd("sw", 6'b101011); tick();
    vec("sw_memwr", 4'd5, 8'h01, 2'b10, 3'd0, 4'b0000); tick();

    // beq taken / not taken
    zero = 1'b1;
    fd("beq_t", 6'b000100);
    vec("beq_taken", 4'd8, 8'h48, 2'b00, 3'd1, 4'b0100); tick();
    zero = 1'b0;
    fd("beq_n", 6'b000100);
    vec("beq_not", 4'd8, 8'h48, 2'b00, 3'd1, 4'b0000); tick();

    // j
    fd("j", 6'b000010);
    vec("j_jump", 4'd10, 8'h80, 2'b00, 3'd0, 4'b0100); tick();

    // addi: regdst must be 0 in ALUWB
    fd("addi", 6'b001000);
    vec("addi_ex", 4'd9, 8'h28, 2'b00, 3'd0, 4'b0000); tick();
    vec("addi_aluwb", 4'd7, 8'h00, 2'b00, 3'd0, 4'b0010); tick();

    // bne with zero=0
    zero = 1'b0;
    fd("bne", 6'b000101);
`ifdef CTRL_BNE_EN
    vec("bne_branch", 4'd8, 8'h48, 2'b00, 3'd1, 4'b0100); tick();
`else
    vec("bne_trap", 4'd11, 8'h00, 2'b00, 3'd0, 4'b0001); tick();
    do_reset();
`endif

    // illegal opcode traps and stays trapped
    fd("ill", 6'b111111);
    for (int i = 0; i < 3; i++) begin
      vec("ill_trap", 4'd11, 8'h00, 2'b00, 3'd0, 4'b0001); tick();
    end
    do_reset();

    // illegal func in REX
    func = 6'b111111;
    fd("badfn", 6'b000000);
    vec("badfn_rex", 4'd6, 8'h08, 2'b00, 3'd0, 4'b0000); tick();
    vec("badfn_trap", 4'd11, 8'h00, 2'b00, 3'd0, 4'b0001);
    do_reset();

    // reset in the middle of MEMRD
    fd("rst", 6'b100011); tick();
    mem_ready = 1'b0; tick();
    vec("rst_pre_memrd", 4'd3, 8'h01, 2'b01, 3'd0, 4'b0000);
    reset = 1'b1;
    vec("rst_outputs_zero", 4'd0, 8'h00, 2'b00, 3'd0, 4'b0000);
    tick();
    reset = 1'b0;
    vec("rst_fetch", 4'd0, 8'h10, 2'b01, 3'd0, 4'b0000);
    do_reset();

    // FETCH timeout: 15 stalled cycles, 16th has no strobe, then TRAP
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      vec("to_wait", 4'd0, 8'h10, 2'b01, 3'd0, 4'b0000); tick();
    end
    vec("to_last", 4'd0, 8'h00, 2'b00, 3'd0, 4'b0000); tick();
    vec("to_trap", 4'd11, 8'h00, 2'b00, 3'd0, 4'b0001);
    do_reset();

    // completion on the final timeout cycle wins
    op = 6'b000000; func = 6'b100000; mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    mem_ready = 1'b1;
    vec("to_complete", 4'd0, 8'h10, 2'b01, 3'd0, 4'b1100); tick();
    vec("to_decode", 4'd1, 8'h30, 2'b00, 3'd0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end
endmodule
